// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// state encodings, iteration count and the decode opcodes.
package multdiv_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;
   localparam int ITER  = 32;

   localparam logic [4:0] OP_MUL = 5'b00110;
   localparam logic [4:0] OP_DIV = 5'b00111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL_RUN,
      S_DIV_RUN,
      S_DONE
   } md_state_t;

endpackage

// File: rtl/md_addsub.sv
// Shared add/subtract used by both the Booth step and the
// restoring-divide step; subtract is b inverted plus carry-in.
module md_addsub
   import multdiv_pkg::*;
#(
   parameter int W = WIDTH + 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic [W-1:0] sum
);

   assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide
// sharing one adder; fixed 33-cycle latency, restartable any time.
module multdiv
   import multdiv_pkg::*;
#(
   parameter int WIDTH_P = WIDTH,
   parameter int CNT_W_P = CNT_W
) (
   input  logic               clock,
   input  logic               ctrl_reset,
   input  logic [WIDTH_P-1:0] data_operandA,
   input  logic [WIDTH_P-1:0] data_operandB,
   input  logic               ctrl_MULT,
   input  logic               ctrl_DIV,
   output logic [WIDTH_P-1:0] data_result,
   output logic               data_exception,
   output logic               data_resultRDY
);

   localparam logic [CNT_W_P-1:0] LAST = CNT_W_P'(ITER - 1);

   md_state_t          state;
   logic [CNT_W_P-1:0] cnt;
   // hi: Booth high word or divide remainder
   // lo: Booth low word or divide quotient
   logic [WIDTH_P-1:0] hi;
   logic [WIDTH_P-1:0] lo;
   logic               q1;
   logic [WIDTH_P:0]   opnd;
   logic               neg_q;
   logic               dz;
   logic               ovf;

   logic               start;
   logic [WIDTH_P-1:0] a_mag;
   logic [WIDTH_P-1:0] b_mag;
   logic [1:0]         booth;

   logic [WIDTH_P:0]   add_a;
   logic [WIDTH_P:0]   add_b;
   logic               add_sub;
   logic [WIDTH_P:0]   sum;

   logic [WIDTH_P-1:0] hi_n;
   logic [WIDTH_P-1:0] lo_n;
   logic               q1_n;
   logic [WIDTH_P-1:0] fin_res;
   logic               fin_exc;

   assign start = ctrl_MULT | ctrl_DIV;
   assign booth = {lo[0], q1};

   // 2^31 stays correct as an unsigned 32-bit magnitude
   assign a_mag = data_operandA[WIDTH_P-1] ?
                  -data_operandA : data_operandA;
   assign b_mag = data_operandB[WIDTH_P-1] ?
                  -data_operandB : data_operandB;

   // Steer the shared adder: trial subtract or Booth add/sub
   always_comb begin
      add_a   = {hi[WIDTH_P-1], hi};
      add_b   = '0;
      add_sub = 1'b0;
      if (state == S_DIV_RUN) begin
         add_a   = {hi, lo[WIDTH_P-1]};
         add_b   = opnd;
         add_sub = 1'b1;
      end else begin
         unique case (booth)
            2'b01: add_b = opnd;
            2'b10: begin
               add_b   = opnd;
               add_sub = 1'b1;
            end
            default: add_b = '0;
         endcase
      end
   end

   md_addsub #(.W(WIDTH_P + 1)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (add_sub),
      .cin (add_sub),
      .sum (sum)
   );

   // Next iteration state: Booth shift keeps the 33-bit sign,
   // divide restores when the trial difference goes negative
   always_comb begin
      hi_n = sum[WIDTH_P:1];
      lo_n = {sum[0], lo[WIDTH_P-1:1]};
      q1_n = lo[0];
      if (state == S_DIV_RUN) begin
         hi_n = sum[WIDTH_P] ? add_a[WIDTH_P-1:0] :
                               sum[WIDTH_P-1:0];
         lo_n = {lo[WIDTH_P-2:0], ~sum[WIDTH_P]};
         q1_n = 1'b0;
      end
   end

   // Final result formed from the last iteration's values
   always_comb begin
      fin_res = lo_n;
      fin_exc = (hi_n != {WIDTH_P{lo_n[WIDTH_P-1]}});
      if (state == S_DIV_RUN) begin
         if (dz) begin
            fin_res = '0;
            fin_exc = 1'b1;
         end else begin
            fin_res = neg_q ? -lo_n : lo_n;
            fin_exc = ovf;
         end
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         hi             <= '0;
         lo             <= '0;
         q1             <= 1'b0;
         opnd           <= '0;
         neg_q          <= 1'b0;
         dz             <= 1'b0;
         ovf            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else if (start) begin
         cnt            <= '0;
         hi             <= '0;
         q1             <= 1'b0;
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            state <= S_MUL_RUN;
            lo    <= data_operandB;
            opnd  <= {data_operandA[WIDTH_P-1], data_operandA};
         end else begin
            state <= S_DIV_RUN;
            lo    <= a_mag;
            opnd  <= {1'b0, b_mag};
            neg_q <= data_operandA[WIDTH_P-1] ^
                     data_operandB[WIDTH_P-1];
            dz    <= (data_operandB == '0);
            ovf   <= (data_operandA == {1'b1, {(WIDTH_P-1){1'b0}}})
                  && (data_operandB == {WIDTH_P{1'b1}});
         end
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state)
            S_MUL_RUN, S_DIV_RUN: begin
               hi  <= hi_n;
               lo  <= lo_n;
               q1  <= q1_n;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state          <= S_DONE;
                  cnt            <= '0;
                  data_result    <= fin_res;
                  data_exception <= fin_exc;
                  data_resultRDY <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: stimulus pushes expected results
// from an arithmetic reference, a monitor pops on each RDY.
module tb_multdiv;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          due;
   } exp_t;

   logic        clock = 1'b0;
   logic        ctrl_reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   multdiv dut (
      .clock          (clock),
      .ctrl_reset     (ctrl_reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic exp_t model(bit m, logic [31:0] a,
                                  logic [31:0] b, int due);
      exp_t   r;
      longint p;
      int     sa;
      int     sbv;
      logic [31:0] lo;
      r.due = due;
      if (m) begin
         p     = longint'(signed'(a)) * longint'(signed'(b));
         lo    = p[31:0];
         r.res = lo;
         r.exc = (p != longint'(signed'(lo)));
      end else if (b == 32'h0) begin
         r.res = 32'h0;
         r.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r.res = 32'h8000_0000;
         r.exc = 1'b1;
      end else begin
         sa    = a;
         sbv   = b;
         r.res = sa / sbv;
         r.exc = 1'b0;
      end
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: any RDY must match the head of the scoreboard
   initial forever begin
      exp_t e;
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rdy: RDY at cycle %0d, none due",
                     cyc);
         end else begin
            e = sb.pop_front();
            check("rdy_cycle", cyc, e.due);
            check("result", data_result, e.res);
            check("exception", {31'b0, data_exception},
                  {31'b0, e.exc});
         end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL rdy_timeout: none by cycle %0d, due %0d",
                  cyc, e.due);
      end
   end

   // Idle cycles with operands scrambled; they must be ignored
   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         ctrl_MULT     = 1'b0;
         ctrl_DIV      = 1'b0;
         data_operandA = $urandom;
         data_operandB = $urandom;
         @(negedge clock);
      end
   endtask

   // Issue a start in the current cycle; aborts any pending op
   task automatic start_op(bit m, bit d, logic [31:0] a,
                           logic [31:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      sb.delete();
      sb.push_back(model(m, a, b, cyc + 33));
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && sb.size() > 0; i++)
         idle(1);
      idle(2);
   endtask

   task automatic pick(output logic [31:0] v);
      logic [31:0] sp [6];
      sp = '{32'h0, 32'h1, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
      if ($urandom_range(0, 3) == 0)
         v = sp[$urandom_range(0, 5)];
      else if ($urandom_range(0, 1) == 0)
         v = $urandom_range(0, 2000) - 1000;
      else
         v = $urandom;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit          rm;

      repeat (3) @(negedge clock);
      ctrl_reset = 1'b0;
      check("reset_result", data_result, 32'h0);
      check("reset_exc", {31'b0, data_exception}, 32'h0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);

      start_op(1, 0, 32'd7, -32'sd3);
      wait_done();
      start_op(1, 0, 32'h0001_0000, 32'h0001_0000);
      wait_done();
      start_op(1, 0, 32'h8000_0000, 32'h1);
      wait_done();
      start_op(0, 1, -32'sd100, 32'd7);
      wait_done();
      start_op(0, 1, 32'd100, -32'sd7);
      wait_done();
      start_op(0, 1, 32'd5, 32'd0);
      wait_done();
      start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();

      start_op(0, 1, 32'd100, 32'd10);
      idle(9);
      start_op(1, 0, 32'd6, 32'd7);
      wait_done();

      start_op(1, 1, 32'd6, 32'd7);
      wait_done();

      start_op(1, 0, 32'h0001_0000, 32'h0001_0000);
      idle(4);
      ctrl_reset = 1'b1;
      sb.delete();
      @(negedge clock);
      ctrl_reset = 1'b0;
      check("abort_result", data_result, 32'h0);
      check("abort_exc", {31'b0, data_exception}, 32'h0);
      idle(45);

      for (int n = 0; n < 40; n++) begin
         pick(ra);
         pick(rb);
         rm = $urandom_range(0, 1);
         start_op(rm, !rm, ra, rb);
         if ($urandom_range(0, 4) == 0) begin
            idle($urandom_range(0, 30));
            pick(ra);
            pick(rb);
            start_op(!rm, rm, ra, rb);
         end
         wait_done();
      end

      idle(3);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: %0d results never arrived",
                  sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
